// File: rtl/rio_blink_shiftreg.sv
// rio_blink_shiftreg
//   Top-level I/O block for the iCEBreaker blinky build. Toggles a heartbeat
//   LED from the system clock and continuously scans one expansion port made
//   of a 74HC595 output register and a 74HC165 input register that share a
//   shift clock and a load line. The word read from the '165 is mirrored to
//   the '595 on the next frame, with bit 0 replaced by the heartbeat.
//
// Ports
//   sysclk_in                  in   system clock, rising edge
//   rst_n                      in   asynchronous active-low reset
//   BLINK_LED                  out  heartbeat LED
//   EXPANSION0_SHIFTREG_CLOCK  out  shift clock ('595 SRCLK, '165 CLK)
//   EXPANSION0_SHIFTREG_LOAD   out  '595 RCLK / '165 SH/LD_n
//   EXPANSION0_SHIFTREG_OUT    out  serial data to '595 SER
//   EXPANSION0_SHIFTREG_IN     in   serial data from '165 QH
//
// Scan FSM
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_RESET | held in reset; the first edge afterwards starts a frame
//   ST_LOAD  | LOAD low for 2H cycles, '165 parallel-loads, out_word captured
//   ST_BIT   | one bit per 2H cycles, bit_idx W-1 down to 0, CLOCK high last H

module rio_blink_shiftreg #(
    parameter int CLK_FREQ    = 12000000,
    parameter int BLINK_HZ    = 1,
    parameter int SHIFT_WIDTH = 8,
    parameter int SCLK_DIV    = 2
) (
    input  logic sysclk_in,
    input  logic rst_n,
    output logic BLINK_LED,
    output logic EXPANSION0_SHIFTREG_CLOCK,
    output logic EXPANSION0_SHIFTREG_LOAD,
    output logic EXPANSION0_SHIFTREG_OUT,
    input  logic EXPANSION0_SHIFTREG_IN
);
    localparam int W         = SHIFT_WIDTH;
    localparam int H         = SCLK_DIV;
    localparam int BLINK_MAX = CLK_FREQ / (2 * BLINK_HZ) - 1;
    localparam int BW        = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;
    localparam int PW        = $clog2(2 * H);
    localparam int KW        = $clog2(W);

    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_MAX);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * H - 1);
    localparam logic [PW-1:0] PH_HIGH  = PW'(H);
    localparam logic [KW-1:0] K_TOP    = KW'(W - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [BW-1:0] blink_cnt;
    logic          blink_led;
    logic          blink_nxt;

    assign blink_nxt = (blink_cnt == BLINK_TC) ? ~blink_led : blink_led;

    always_ff @(posedge sysclk_in or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_led <= 1'b0;
        end else begin
            blink_led <= blink_nxt;
            blink_cnt <= (blink_cnt == BLINK_TC) ? '0 : blink_cnt + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    state_t         state, state_nxt;
    logic [PW-1:0]  ph_cnt, ph_cnt_nxt;
    logic [KW-1:0]  bit_idx, bit_idx_nxt;

    always_ff @(posedge sysclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            ph_cnt  <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            ph_cnt  <= ph_cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next state (phase timer counts down to terminal 0)
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        ph_cnt_nxt  = ph_cnt;
        bit_idx_nxt = bit_idx;
        unique case (state)
            ST_RESET: begin
                state_nxt  = ST_LOAD;
                ph_cnt_nxt = PH_LAST;
            end
            ST_LOAD: begin
                if (ph_cnt == '0) begin
                    state_nxt   = ST_BIT;
                    ph_cnt_nxt  = PH_LAST;
                    bit_idx_nxt = K_TOP;
                end else begin
                    ph_cnt_nxt = ph_cnt - PW'(1);
                end
            end
            ST_BIT: begin
                if (ph_cnt == '0) begin
                    ph_cnt_nxt = PH_LAST;
                    if (bit_idx == '0) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        bit_idx_nxt = bit_idx - KW'(1);
                    end
                end else begin
                    ph_cnt_nxt = ph_cnt - PW'(1);
                end
            end
            default: begin
                state_nxt  = ST_LOAD;
                ph_cnt_nxt = PH_LAST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan FSM: outputs. Pin values are decoded from the next state so the
    // pins themselves come straight out of flops.
    // ------------------------------------------------------------------
    logic [1:0]   in_sync;
    logic [W-1:0] shift_in;
    logic [W-1:0] in_word, in_word_nxt;
    logic [W-1:0] out_word, out_word_nxt;
    logic         sclk_q, load_q, sout_q;
    logic         sclk_nxt, load_nxt, sout_nxt;
    logic         frame_end, load_entry, sample;

    always_comb begin
        frame_end  = (state == ST_BIT) && (ph_cnt == '0) && (bit_idx == '0);
        load_entry = (state_nxt == ST_LOAD) && (state != ST_LOAD);
        // The word finished on this edge is already the one mirrored out in
        // the frame that starts on this same edge.
        in_word_nxt  = frame_end ? shift_in : in_word;
        out_word_nxt = load_entry ? {in_word_nxt[W-1:1], blink_nxt} : out_word;
        load_nxt = (state_nxt != ST_LOAD);
        sclk_nxt = (state_nxt == ST_BIT) && (ph_cnt_nxt < PH_HIGH);
        sout_nxt = 1'b0;
        if (state_nxt == ST_LOAD) begin
            sout_nxt = out_word_nxt[W-1];
        end else if (state_nxt == ST_BIT) begin
            sout_nxt = out_word_nxt[bit_idx_nxt];
        end
        // Sample on the edge that raises CLOCK: QH still holds the bit that
        // was presented before the '165 shifts.
        sample = sclk_nxt && !sclk_q;
    end

    always_ff @(posedge sysclk_in or negedge rst_n) begin
        if (!rst_n) begin
            in_sync  <= '0;
            shift_in <= '0;
            in_word  <= '0;
            out_word <= '0;
            sclk_q   <= 1'b0;
            load_q   <= 1'b1;
            sout_q   <= 1'b0;
        end else begin
            in_sync  <= {in_sync[0], EXPANSION0_SHIFTREG_IN};
            if (sample) begin
                shift_in <= {shift_in[W-2:0], in_sync[1]};
            end
            in_word  <= in_word_nxt;
            out_word <= out_word_nxt;
            sclk_q   <= sclk_nxt;
            load_q   <= load_nxt;
            sout_q   <= sout_nxt;
        end
    end

    assign BLINK_LED                 = blink_led;
    assign EXPANSION0_SHIFTREG_CLOCK = sclk_q;
    assign EXPANSION0_SHIFTREG_LOAD  = load_q;
    assign EXPANSION0_SHIFTREG_OUT   = sout_q;

endmodule

// File: tb/tb_rio_blink_shiftreg.sv
// tb_rio_blink_shiftreg
//   Directed bench for rio_blink_shiftreg. Three instances share clock and
//   reset: defaults (with '165/'595 models), a fast blink build, and a
//   W=16/H=1 build fed by a source aligned to its sampling instants.

module tb_rio_blink_shiftreg;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // default build
    logic m_led, m_sclk, m_load, m_sout, m_sin;
    // fast blink build
    logic b_led, b_sclk, b_load, b_sout;
    // wide / fast-scan build
    logic s_led, s_sclk, s_load, s_sout, s_sin;

    rio_blink_shiftreg u_main (
        .sysclk_in                 (clk),
        .rst_n                     (rst_n),
        .BLINK_LED                 (m_led),
        .EXPANSION0_SHIFTREG_CLOCK (m_sclk),
        .EXPANSION0_SHIFTREG_LOAD  (m_load),
        .EXPANSION0_SHIFTREG_OUT   (m_sout),
        .EXPANSION0_SHIFTREG_IN    (m_sin)
    );

    rio_blink_shiftreg #(.CLK_FREQ(100), .BLINK_HZ(5)) u_blink (
        .sysclk_in                 (clk),
        .rst_n                     (rst_n),
        .BLINK_LED                 (b_led),
        .EXPANSION0_SHIFTREG_CLOCK (b_sclk),
        .EXPANSION0_SHIFTREG_LOAD  (b_load),
        .EXPANSION0_SHIFTREG_OUT   (b_sout),
        .EXPANSION0_SHIFTREG_IN    (1'b0)
    );

    rio_blink_shiftreg #(.SHIFT_WIDTH(16), .SCLK_DIV(1)) u_sweep (
        .sysclk_in                 (clk),
        .rst_n                     (rst_n),
        .BLINK_LED                 (s_led),
        .EXPANSION0_SHIFTREG_CLOCK (s_sclk),
        .EXPANSION0_SHIFTREG_LOAD  (s_load),
        .EXPANSION0_SHIFTREG_OUT   (s_sout),
        .EXPANSION0_SHIFTREG_IN    (s_sin)
    );

    // '165 model: low LOAD parallel-loads, CLOCK rise shifts toward QH
    logic [7:0] pat165;
    logic [7:0] sr165 = 8'h00;
    always @(posedge m_sclk or negedge m_load) begin
        if (!m_load) sr165 <= pat165;
        else         sr165 <= {sr165[6:0], 1'b0};
    end
    assign m_sin = sr165[7];

    // '595 model: CLOCK rise shifts SER in, LOAD rise latches the outputs
    logic [7:0] sr595 = 8'h00;
    logic [7:0] q595  = 8'h00;
    always @(posedge m_sclk) sr595 <= {sr595[6:0], m_sout};
    always @(posedge m_load) q595  <= sr595;

    // H=1 source: presents each bit one bit-slot early so the two-flop
    // synchronizer delay lands the right bit on the sampling edge.
    logic [15:0] pat_sw;
    logic [15:0] sr_sw = 16'h0000;
    always @(posedge s_load or negedge s_load or negedge s_sclk) begin
        if (!s_load) sr_sw <= pat_sw;
        else         sr_sw <= {sr_sw[14:0], 1'b0};
    end
    assign s_sin = sr_sw[15];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle waveforms of one frame, bit i = cycle i of the frame
    function automatic logic [63:0] exp_clk(input int w, input int h);
        logic [63:0] r = '0;
        for (int i = 0; i < 2 * h * (w + 1); i++)
            r[i] = (i >= 2 * h) && (((i - 2 * h) % (2 * h)) >= h);
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input int w, input int h);
        logic [63:0] r = '0;
        for (int i = 0; i < 2 * h * (w + 1); i++)
            r[i] = (i >= 2 * h);
        return r;
    endfunction

    function automatic logic [63:0] exp_out(input logic [15:0] word, input int w, input int h);
        logic [63:0] r = '0;
        for (int i = 0; i < 2 * h * (w + 1); i++)
            r[i] = (i < 2 * h) ? word[w - 1] : word[w - 1 - (i - 2 * h) / (2 * h)];
        return r;
    endfunction

    task automatic run_cycles(input int sel, input int n,
                              output logic [63:0] v_clk, output logic [63:0] v_load,
                              output logic [63:0] v_out, output logic [63:0] v_led);
        v_clk = '0; v_load = '0; v_out = '0; v_led = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            case (sel)
                0: begin
                    v_clk[i] = m_sclk; v_load[i] = m_load; v_out[i] = m_sout; v_led[i] = m_led;
                end
                1: begin
                    v_clk[i] = s_sclk; v_load[i] = s_load; v_out[i] = s_sout; v_led[i] = s_led;
                end
                default: begin
                    v_clk[i] = b_sclk; v_load[i] = b_load; v_out[i] = b_sout; v_led[i] = b_led;
                end
            endcase
        end
    endtask

    logic [63:0] vc, vl, vo, vb, exp_led;

    initial begin
        pat165 = 8'hA5;
        pat_sw = 16'h8001;

        // reset held with clock running
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_main",  {60'd0, m_led, m_sclk, m_load, m_sout}, 64'b0010);
        check_val("reset_blink", {60'd0, b_led, b_sclk, b_load, b_sout}, 64'b0010);
        check_val("reset_sweep", {60'd0, s_led, s_sclk, s_load, s_sout}, 64'b0010);

        // frame 1: LOAD low 4 cycles, 8 clock pulses, all-zero data
        rst_n = 1'b1;
        run_cycles(0, 36, vc, vl, vo, vb);
        check_val("f1_load", vl, exp_load(8, 2));
        check_val("f1_clk",  vc, exp_clk(8, 2));
        check_val("f1_out",  vo, exp_out(16'h0000, 8, 2));

        // frame 2: mirrors A5 captured in frame 1, bit 0 = heartbeat (0)
        pat165 = 8'h3C;
        run_cycles(0, 36, vc, vl, vo, vb);
        check_val("f2_load", vl, exp_load(8, 2));
        check_val("f2_out",  vo, exp_out(16'h00A4, 8, 2));

        // frame 3: mirrors 3C; '595 latched frame-2 data at its LOAD rise
        pat165 = 8'hFF;
        run_cycles(0, 36, vc, vl, vo, vb);
        check_val("f3_out",   vo, exp_out(16'h003C, 8, 2));
        check_val("f3_latch", {56'd0, q595}, 64'h00A4);

        // reset during BIT(3) high phase, asynchronous return to reset values
        run_cycles(0, 23, vc, vl, vo, vb);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_reset", {60'd0, m_led, m_sclk, m_load, m_sout}, 64'b0010);
        pat165 = 8'h81;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(0, 36, vc, vl, vo, vb);
        check_val("post_rst_load", vl, exp_load(8, 2));
        check_val("post_rst_out",  vo, exp_out(16'h0000, 8, 2));
        run_cycles(0, 36, vc, vl, vo, vb);
        check_val("post_rst_f2_out", vo, exp_out(16'h0080, 8, 2));

        // W=16, H=1: 34-cycle frame, 16 pulses, 8001 comes back with bit 0 = LED
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cycles(1, 34, vc, vl, vo, vb);
        check_val("sw_f1_load", vl, exp_load(16, 1));
        check_val("sw_f1_clk",  vc, exp_clk(16, 1));
        check_val("sw_f1_out",  vo, exp_out(16'h0000, 16, 1));
        run_cycles(1, 34, vc, vl, vo, vb);
        check_val("sw_f2_load", vl, exp_load(16, 1));
        check_val("sw_f2_out",  vo, exp_out(16'h8000, 16, 1));

        // blink: CLK_FREQ=100, BLINK_HZ=5 toggles every 10 cycles
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cycles(2, 40, vc, vl, vo, vb);
        exp_led = '0;
        for (int i = 0; i < 40; i++) exp_led[i] = (((i + 1) / 10) % 2) == 1;
        check_val("blink", vb, exp_led);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
